// File: rtl/ex_stage_mc.sv
// ex_stage_mc -- handshaked execute stage with an iterative multiply/divide unit.
//
// Selects the ALU operands, runs single-cycle ALU ops, unsigned shift-add
// multiply and (optionally) restoring divide, and computes branch/jump targets.
// Results sit in an output register behind a valid/ready handshake.
//
// Ports:
//   clk, reset (async, active high), flush (sync kill of in-flight op/result)
//   in_valid/in_ready       : operation handshake
//   shamt_sel, alu_src      : operand A / B select
//   alu_op[3:0]             : 0 AND 1 OR 2 NOR 3 ADD 4 SUB 5 SLT 6 SLL 7 SRL
//                             8 LUI 9 MULU 10 DIVU, others give 0
//   read_data1/2, shamt_ext, imm_ext, pc_4, jump_index : operands
//   out_valid/out_ready     : result handshake
//   alu_result, hi_result, zero, branch_address, jump_address, out_pc_4
//
// Configuration macro: EX_DIVIDER_EN -- when defined, DIVU is an iterative
// restoring divider; otherwise op 10 is a single-cycle op producing 0/0.

module ex_stage_mc #(
   parameter int NBits = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             shamt_sel,
   input  logic             alu_src,
   input  logic [3:0]       alu_op,
   input  logic [NBits-1:0] read_data1,
   input  logic [NBits-1:0] read_data2,
   input  logic [NBits-1:0] shamt_ext,
   input  logic [NBits-1:0] imm_ext,
   input  logic [NBits-1:0] pc_4,
   input  logic [NBits-7:0] jump_index,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NBits-1:0] alu_result,
   output logic [NBits-1:0] hi_result,
   output logic             zero,
   output logic [NBits-1:0] branch_address,
   output logic [NBits-1:0] jump_address,
   output logic [NBits-1:0] out_pc_4
);

   localparam int CW = $clog2(NBits) + 1;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_NOR  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_LUI  = 4'd8;
   localparam logic [3:0] OP_MULU = 4'd9;
`ifdef EX_DIVIDER_EN
   localparam logic [3:0] OP_DIVU = 4'd10;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;
`else
   typedef enum logic [1:0] {S_IDLE, S_MUL} state_e;
`endif

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [NBits-1:0]   acc_hi_q, acc_lo_q;   // mul: {partial hi, multiplier}; div: {remainder, quotient}
   logic [NBits-1:0]   opnd_q;               // mul: multiplicand; div: divisor
   logic               out_valid_q;
   logic [NBits-1:0]   res_q, hi_q, br_q, jmp_q, pc4_q;

   logic [NBits-1:0]   op_a, op_b, sc_res;
   logic               accept, mc_op, last_iter;
   logic [NBits:0]     mul_sum;
   logic [NBits-1:0]   it_hi, it_lo;

   assign op_a = shamt_sel ? shamt_ext : read_data1;
   assign op_b = alu_src   ? imm_ext   : read_data2;

   assign in_ready  = !reset && (state_q == S_IDLE) && (!out_valid_q || out_ready) && !flush;
   assign accept    = in_valid && in_ready;
   assign last_iter = (state_q != S_IDLE) && (cnt_q == CW'(1));

`ifdef EX_DIVIDER_EN
   assign mc_op = (alu_op == OP_MULU) || (alu_op == OP_DIVU);
`else
   assign mc_op = (alu_op == OP_MULU);
`endif

   // Single-cycle ALU; ops outside 0-8 (and DIVU without the divider) give 0.
   always_comb begin
      sc_res = '0;
      case (alu_op)
         OP_AND:  sc_res = op_a & op_b;
         OP_OR:   sc_res = op_a | op_b;
         OP_NOR:  sc_res = ~(op_a | op_b);
         OP_ADD:  sc_res = op_a + op_b;
         OP_SUB:  sc_res = op_a - op_b;
         OP_SLT:  sc_res = {{(NBits-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLL:  sc_res = op_b << op_a[4:0];
         OP_SRL:  sc_res = op_b >> op_a[4:0];
         OP_LUI:  sc_res = op_b << (NBits/2);
         default: sc_res = '0;
      endcase
   end

   // One shift-add multiply step: add multiplicand on the multiplier LSB,
   // then shift the {carry, hi, lo} triple right by one.
   assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

`ifdef EX_DIVIDER_EN
   logic [NBits:0] div_shift, div_diff;
   assign div_shift = {acc_hi_q, acc_lo_q[NBits-1]};
   assign div_diff  = div_shift - {1'b0, opnd_q};
`endif

   always_comb begin
      it_hi = mul_sum[NBits:1];
      it_lo = {mul_sum[0], acc_lo_q[NBits-1:1]};
`ifdef EX_DIVIDER_EN
      // Restoring step; a zero divisor never borrows, so quotient ends
      // all-ones and the remainder collects the whole dividend.
      if (state_q == S_DIV) begin
         if (!div_diff[NBits]) begin
            it_hi = div_diff[NBits-1:0];
            it_lo = {acc_lo_q[NBits-2:0], 1'b1};
         end else begin
            it_hi = div_shift[NBits-1:0];
            it_lo = {acc_lo_q[NBits-2:0], 1'b0};
         end
      end
`endif
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept && (alu_op == OP_MULU)) state_d = S_MUL;
`ifdef EX_DIVIDER_EN
            else if (accept && (alu_op == OP_DIVU)) state_d = S_DIV;
`endif
         end
         default: if (last_iter) state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         opnd_q      <= '0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         hi_q        <= '0;
         br_q        <= '0;
         jmp_q       <= '0;
         pc4_q       <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else if (accept) begin
         // Acceptance implies the result slot is empty or draining now.
         pc4_q <= pc_4;
         br_q  <= pc_4 + {imm_ext[NBits-3:0], 2'b00};
         jmp_q <= {pc_4[NBits-1:NBits-4], jump_index, 2'b00};
         if (mc_op) begin
            cnt_q       <= CW'(NBits);
            acc_hi_q    <= '0;
            acc_lo_q    <= (alu_op == OP_MULU) ? op_b : op_a;
            opnd_q      <= (alu_op == OP_MULU) ? op_a : op_b;
            out_valid_q <= 1'b0;
         end else begin
            res_q       <= sc_res;
            hi_q        <= '0;
            out_valid_q <= 1'b1;
         end
      end else if (state_q != S_IDLE) begin
         // out_valid is always low here: a multi-cycle op only starts
         // when the previous result has left.
         cnt_q    <= cnt_q - CW'(1);
         acc_hi_q <= it_hi;
         acc_lo_q <= it_lo;
         if (last_iter) begin
            res_q       <= it_lo;
            hi_q        <= it_hi;
            out_valid_q <= 1'b1;
         end
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid      = out_valid_q;
   assign alu_result     = res_q;
   assign hi_result      = hi_q;
   assign zero           = (res_q == '0);
   assign branch_address = br_q;
   assign jump_address   = jmp_q;
   assign out_pc_4       = pc4_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
module tb_ex_stage_mc;

`ifdef EX_DIVIDER_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0;
   logic        shamt_sel = 1'b0, alu_src = 1'b0, out_ready = 1'b1;
   logic [3:0]  alu_op = '0;
   logic [31:0] rd1 = '0, rd2 = '0, shamt = '0, imm = '0, pc4 = '0;
   logic [25:0] jidx = '0;
   logic        in_ready, out_valid, zero;
   logic [31:0] alu_result, hi_result, branch_address, jump_address, out_pc_4;

   // 16-bit instance
   logic        flush16 = 1'b0, in_valid16 = 1'b0, sel16 = 1'b0, src16 = 1'b0, ordy16 = 1'b1;
   logic [3:0]  op16 = '0;
   logic [15:0] a16 = '0, b16 = '0, sh16 = '0, imm16 = '0, pc16 = '0;
   logic [9:0]  jidx16 = '0;
   logic        in_ready16, out_valid16, zero16;
   logic [15:0] res16, hi16, br16, jmp16, opc16;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   ex_stage_mc #(.NBits(32)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .shamt_sel(shamt_sel), .alu_src(alu_src), .alu_op(alu_op),
      .read_data1(rd1), .read_data2(rd2), .shamt_ext(shamt), .imm_ext(imm), .pc_4(pc4),
      .jump_index(jidx), .out_valid(out_valid), .out_ready(out_ready),
      .alu_result(alu_result), .hi_result(hi_result), .zero(zero),
      .branch_address(branch_address), .jump_address(jump_address), .out_pc_4(out_pc_4));

   ex_stage_mc #(.NBits(16)) u16 (
      .clk(clk), .reset(reset), .flush(flush16), .in_valid(in_valid16), .in_ready(in_ready16),
      .shamt_sel(sel16), .alu_src(src16), .alu_op(op16),
      .read_data1(a16), .read_data2(b16), .shamt_ext(sh16), .imm_ext(imm16), .pc_4(pc16),
      .jump_index(jidx16), .out_valid(out_valid16), .out_ready(ordy16),
      .alu_result(res16), .hi_result(hi16), .zero(zero16),
      .branch_address(br16), .jump_address(jmp16), .out_pc_4(opc16));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: what each op means arithmetically.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] lo, output logic [31:0] hi);
      logic [63:0] p;
      p  = 64'(a) * 64'(b);
      lo = '0;
      hi = '0;
      case (op)
         4'd0: lo = a & b;
         4'd1: lo = a | b;
         4'd2: lo = ~(a | b);
         4'd3: lo = a + b;
         4'd4: lo = a - b;
         4'd5: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6: lo = b << a[4:0];
         4'd7: lo = b >> a[4:0];
         4'd8: lo = b << 16;
         4'd9: begin lo = p[31:0]; hi = p[63:32]; end
         4'd10: if (DIV_EN) begin
            if (b == 0) begin lo = '1; hi = a; end
            else begin lo = a / b; hi = a % b; end
         end
         default: ;
      endcase
   endfunction

   // Issue one op at a negedge using the current sel/shamt/imm/pc4/jidx,
   // scramble all inputs after acceptance, then check result and latency.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a_reg,
                         input logic [31:0] b_reg);
      logic [31:0] a, b, elo, ehi, ebr, ejmp, epc;
      int n, lat, elat;
      a    = shamt_sel ? shamt : a_reg;
      b    = alu_src ? imm : b_reg;
      model(op, a, b, elo, ehi);
      ebr  = pc4 + (imm << 2);
      ejmp = {pc4[31:28], jidx, 2'b00};
      epc  = pc4;
      elat = (op == 4'd9 || (DIV_EN && op == 4'd10)) ? 33 : 1;
      alu_op = op; rd1 = a_reg; rd2 = b_reg; in_valid = 1'b1;
      #1;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
      chk({tag, "_accept"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      rd1 = $urandom; rd2 = $urandom; shamt = $urandom; imm = $urandom;
      pc4 = $urandom; jidx = 26'($urandom); alu_op = 4'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         chk({tag, "_busy_in_ready"}, in_ready, 0);
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, elat);
      chk({tag, "_lo"}, alu_result, elo);
      chk({tag, "_hi"}, hi_result, ehi);
      chk({tag, "_zero"}, zero, (elo == 0));
      chk({tag, "_branch"}, branch_address, ebr);
      chk({tag, "_jump"}, jump_address, ejmp);
      chk({tag, "_pc4"}, out_pc_4, epc);
   endtask

   initial begin
      int lat;
      // ---- reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu", alu_result, 0);
      chk("rst_hi", hi_result, 0);
      chk("rst_zero", zero, 1);
      chk("rst_branch", branch_address, 0);
      chk("rst_pc4", out_pc_4, 0);
      reset = 1'b0;
      #1 chk("post_rst_in_ready", in_ready, 1);

      // ---- reset mid-MULU
      @(negedge clk);
      alu_op = 4'd9; rd1 = 32'd123; rd2 = 32'd456; in_valid = 1'b1;
      #1 chk("rmul_accept", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1 chk("rmul_in_ready_rst", in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rmul_out_valid", out_valid, 0);
      chk("rmul_alu", alu_result, 0);
      chk("rmul_zero", zero, 1);
      chk("rmul_in_ready", in_ready, 1);
      repeat (36) @(negedge clk);
      chk("rmul_no_late_result", out_valid, 0);
      run_op("add_after_rst", 4'd3, 32'd3, 32'd4);

      // ---- back-to-back single-cycle ops
      shamt_sel = 1'b0; alu_src = 1'b0;
      @(negedge clk);
      alu_op = 4'd3; rd1 = 32'hFFFF_FFFF; rd2 = 32'd1; in_valid = 1'b1;
      #1 chk("b2b_rdy0", in_ready, 1);
      @(negedge clk);
      chk("b2b_add_v", out_valid, 1);
      chk("b2b_add", alu_result, 0);
      chk("b2b_add_z", zero, 1);
      alu_op = 4'd4; rd1 = 32'd5; rd2 = 32'd5;
      #1 chk("b2b_rdy1", in_ready, 1);
      @(negedge clk);
      chk("b2b_sub_v", out_valid, 1);
      chk("b2b_sub", alu_result, 0);
      chk("b2b_sub_z", zero, 1);
      alu_op = 4'd5; rd1 = 32'hFFFF_FFFF; rd2 = 32'd1;
      #1 chk("b2b_rdy2", in_ready, 1);
      @(negedge clk);
      chk("b2b_slt_v", out_valid, 1);
      chk("b2b_slt", alu_result, 1);
      chk("b2b_slt_z", zero, 0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_drained", out_valid, 0);

      // ---- MULU / DIVU
      shamt_sel = 1'b0; alu_src = 1'b0;
      run_op("mulu_max", 4'd9, 32'hFFFF_FFFF, 32'd2);
      chk("mulu_hi_lit", hi_result, 32'd1);
      chk("mulu_lo_lit", alu_result, 32'hFFFF_FFFE);
      shamt_sel = 1'b0; alu_src = 1'b0;
      run_op("divu_100_7", 4'd10, 32'd100, 32'd7);
      chk("divu_q_lit", alu_result, DIV_EN ? 32'd14 : 32'd0);
      chk("divu_r_lit", hi_result, DIV_EN ? 32'd2 : 32'd0);
      shamt_sel = 1'b0; alu_src = 1'b0;
      run_op("divu_by0", 4'd10, 32'd9, 32'd0);
      chk("divu0_q_lit", alu_result, DIV_EN ? 32'hFFFF_FFFF : 32'd0);
      chk("divu0_r_lit", hi_result, DIV_EN ? 32'd9 : 32'd0);

      // ---- branch / jump targets
      shamt_sel = 1'b0; alu_src = 1'b1;
      pc4 = 32'h0040_0004; imm = 32'hFFFF_FFFF; jidx = 26'h010_0000;
      run_op("addr", 4'd3, 32'd1, 32'd0);
      chk("addr_branch_lit", branch_address, 32'h0040_0000);
      chk("addr_jump_lit", jump_address, 32'h0040_0000);

      // ---- stall 4 cycles, flush in the 3rd with in_valid high
      shamt_sel = 1'b0; alu_src = 1'b0; pc4 = 32'h0000_1000;
      @(negedge clk);
      alu_op = 4'd1; rd1 = 32'hF0F0_0000; rd2 = 32'h0000_0F0F; in_valid = 1'b1; out_ready = 1'b0;
      #1 chk("stall_accept", in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_alu", alu_result, 32'hF0F0_0F0F);
         chk("stall_hi", hi_result, 0);
         chk("stall_pc4", out_pc_4, 32'h0000_1000);
         alu_op = 4'd3; rd1 = 32'd5 + i; rd2 = 32'd2; pc4 = $urandom;
         if (i == 2) flush = 1'b1;
         #1 chk("stall_in_ready", in_ready, 0);
      end
      @(negedge clk);
      flush = 1'b0;
      chk("flush_drop", out_valid, 0);
      #1 chk("flush_next_ready", in_ready, 1);
      @(negedge clk);
      chk("flush_next_valid", out_valid, 1);
      chk("flush_next_alu", alu_result, 32'd9);
      in_valid = 1'b0; out_ready = 1'b1;

      // ---- flush aborts a MULU
      @(negedge clk);
      alu_op = 4'd9; rd1 = 32'd77; rd2 = 32'd88; in_valid = 1'b1;
      #1 chk("fmul_accept", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      flush = 1'b1;
      #1 chk("fmul_flush_rdy", in_ready, 0);
      @(negedge clk);
      flush = 1'b0;
      #1 chk("fmul_idle", in_ready, 1);
      repeat (36) @(negedge clk);
      chk("fmul_no_result", out_valid, 0);

      // ---- randomized ops against the model
      for (int k = 0; k < 40; k++) begin
         logic [31:0] ra, rb;
         shamt_sel = 1'($urandom); alu_src = 1'($urandom);
         shamt = $urandom; imm = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         pc4 = $urandom; jidx = 26'($urandom);
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         run_op("rand", 4'($urandom_range(0, 15)), ra, rb);
      end

      // ---- 16-bit variant
      @(negedge clk);
      op16 = 4'd3; a16 = 16'hFFFF; b16 = 16'd2; pc16 = 16'h1234; imm16 = 16'h0001;
      jidx16 = 10'h3FF; in_valid16 = 1'b1;
      #1 chk("w16_ready", in_ready16, 1);
      @(negedge clk);
      chk("w16_add_v", out_valid16, 1);
      chk("w16_add", res16, 16'h0001);
      chk("w16_branch", br16, 16'h1238);
      chk("w16_jump", jmp16, 16'h1FFC);
      op16 = 4'd6; a16 = 16'd4; b16 = 16'h0F0F;
      @(negedge clk);
      chk("w16_sll", res16, 16'hF0F0);
      op16 = 4'd9; a16 = 16'hFFFF; b16 = 16'hFFFF;
      #1 chk("w16_mul_ready", in_ready16, 1);
      @(negedge clk);
      in_valid16 = 1'b0;
      lat = 1;
      while (out_valid16 !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
      chk("w16_mul_lat", lat, 17);
      chk("w16_mul_lo", res16, 16'h0001);
      chk("w16_mul_hi", hi16, 16'hFFFE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised, handshaked execute stage that replaces the purely combinational execute path of the single-cycle core. It selects ALU operands (register/shamt, register/immediate), runs single-cycle ALU ops and iterative unsigned multiply/divide, and computes branch and jump targets. Results are registered behind a valid/ready handshake, so the pipelined core can stall on multi-cycle ops. It sits between the ID/EX register and the MEM stage.

## Interface
- NBits, 32: datapath width; even, ≥ 8.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of in-flight op and held result.
- in_valid  input  1  operation presented.
- in_ready  output  1  stage can accept this cycle.
- shamt_sel  input  1  1: A = shamt_ext, 0: A = read_data1.
- alu_src  input  1  1: B = imm_ext, 0: B = read_data2.
- alu_op  input  4  operation code (see Operation).
- read_data1, read_data2, shamt_ext, imm_ext, pc_4  input  NBits each  operands.
- jump_index  input  NBits-6  unshifted jump field.
- out_valid  output  1  result registered and valid.
- out_ready  input  1  downstream accepts result.
- alu_result  output  NBits  primary result.
- hi_result  output  NBits  mul high word / div remainder; 0 for other ops.
- zero  output  1  alu_result == 0.
- branch_address  output  NBits  pc_4 + (imm_ext << 2), modulo 2^NBits.
- jump_address  output  NBits  {pc_4[NBits-1:NBits-4], jump_index, 2'b00}.
- out_pc_4  output  NBits  registered pc_4.

## Operation
- alu_op: 0 AND, 1 OR, 2 NOR, 3 ADD, 4 SUB, 5 SLT (signed), 6 SLL B by A[4:0], 7 SRL B by A[4:0], 8 LUI (B << NBits/2), 9 MULU, 10 DIVU; 11–15 produce alu_result = 0.
- ADD/SUB wrap modulo 2^NBits; no overflow flag.
- Handshake: transfer on in_valid && in_ready; in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush.
- FSM: IDLE -> (ops 0–8) IDLE, result register loaded; IDLE -> (9) MUL; IDLE -> (10) DIV; MUL/DIV count NBits iterations -> IDLE with result loaded.
- MULU: shift-add, {hi_result, alu_result} = A × B unsigned, 2·NBits product.
- DIVU: restoring; alu_result = quotient, hi_result = remainder. B == 0 -> quotient all-ones, remainder = A, still NBits iterations.
- Operands, pc_4, jump_index, and branch/jump addresses are captured at acceptance; later input changes do not affect an in-flight op.
- Held result: while out_valid && !out_ready, all outputs are stable.
- flush: clears out_valid, aborts MUL/DIV to IDLE, and blocks acceptance that cycle. It wins over in_valid and out_ready.
- reset mid-op: immediate abort to IDLE.

## Timing
- Reset values: out_valid 0, in_ready 0 while reset is asserted, and 1 in the first cycle after, if no flush. All data outputs 0; zero = 1.
- Single-cycle ops: out_valid one cycle after acceptance. Back-to-back throughput is 1/cycle when out_ready = 1.
- MULU/DIVU: out_valid NBits + 1 cycles after acceptance. in_ready is 0 for those NBits + 1 cycles, or longer if the output is stalled.
- Accepting into an empty slot while the result slot drains is legal: result popped and new op accepted in the same cycle.
- Iteration counter is $clog2(NBits)+1 bits and saturates at IDLE.

## Configuration
- EX_DIVIDER_EN defined: DIVU as specified.
- Not defined: no divider logic. alu_op 10 behaves as a single-cycle op with alu_result = 0 and hi_result = 0, and the DIV state does not exist.

## Test plan
- Reset mid-MULU (cycle 5): after release, out_valid = 0, alu_result = 0, zero = 1; the next ADD 3+4 returns 7 one cycle after acceptance.
- ADD 0xFFFFFFFF + 1, then SUB 5−5, then SLT −1 < 1, back-to-back with out_ready = 1: results 0/zero=1, 0/zero=1, 1, on consecutive cycles.
- MULU 0xFFFFFFFF × 2 (NBits=32): hi = 1, lo = 0xFFFFFFFE, out_valid exactly 33 cycles after acceptance, in_ready low throughout.
- DIVU 100/7 -> q = 14, r = 2; DIVU 9/0 -> q = 0xFFFFFFFF, r = 9 (EX_DIVIDER_EN). Without the macro: DIVU 100/7 -> 0/0 after 1 cycle.
- out_ready = 0 for 4 cycles with a valid result: outputs stable, in_ready = 0. Flush in cycle 3 with in_valid = 1: out_valid drops, nothing accepted, and the next op accepted the cycle after.
- pc_4 = 0x00400004, imm_ext = 0xFFFFFFFF, jump_index = 0x0100000: branch_address = 0x00400000, jump_address = 0x00400000; NBits=16 variant rerun with ADD/SLL.
